// File: rtl/pc_gen.sv
// Program-counter generator feeding the fetch stage: sequential +4 on handshake, trap/redirect reload.
// Optional misaligned-target fault handling is enabled with PC_GEN_MISALIGN_CHECK_EN.
module pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_pc_i,
  input  logic        halt_i,
  output logic [63:0] pc_o,
  output logic        pc_valid_o,
  input  logic        pc_ready_i,
  output logic        misaligned_o,
  output logic [63:0] misaligned_pc_o
);

`ifdef PC_GEN_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

  state_t      state;
  logic [63:0] pc_q;
  logic        load;
  logic [63:0] target;
  logic        handshake;

  // Trap outranks redirect; a dropped redirect never reaches pc_q.
  assign load       = trap_valid_i | redirect_valid_i;
  assign target     = trap_valid_i ? trap_pc_i : redirect_pc_i;
  assign pc_valid_o = (state == RUN) & ~halt_i;
  assign handshake  = pc_valid_o & pc_ready_i;
  assign pc_o       = pc_q;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  logic        target_bad;
  logic        mis_q;
  logic [63:0] mis_pc_q;

  assign target_bad      = load & (target[1:0] != 2'b00);
  assign misaligned_o    = mis_q;
  assign misaligned_pc_o = mis_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc_q     <= RESET_PC;
      mis_q    <= 1'b0;
      mis_pc_q <= '0;
    end else begin
      case (state)
        BOOT, RUN: begin
          if (target_bad) begin
            // pc_q keeps the last good address while faulted
            state    <= FAULT;
            mis_q    <= 1'b1;
            mis_pc_q <= target;
          end else begin
            state <= RUN;
            if (load)           pc_q <= target;
            else if (handshake) pc_q <= pc_q + 64'd4;
          end
        end
        FAULT: begin
          // Only an aligned trap leaves FAULT; redirects are ignored here.
          if (trap_valid_i) begin
            if (trap_pc_i[1:0] == 2'b00) begin
              state <= RUN;
              pc_q  <= trap_pc_i;
            end else begin
              mis_pc_q <= trap_pc_i;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
`else
  assign misaligned_o    = 1'b0;
  assign misaligned_pc_o = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
    end else begin
      state <= RUN;
      if (load)           pc_q <= target & ~64'h3;
      else if (handshake) pc_q <= pc_q + 64'd4;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; covers both builds of PC_GEN_MISALIGN_CHECK_EN.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [63:0] trap_pc_i;
  logic        halt_i;
  logic [63:0] pc_o;
  logic        pc_valid_o;
  logic        pc_ready_i;
  logic        misaligned_o;
  logic [63:0] misaligned_pc_o;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] RST = 64'h0000_0000_8000_0000;

  pc_gen #(.RESET_PC(RST)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .halt_i(halt_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_ready_i(pc_ready_i),
    .misaligned_o(misaligned_o), .misaligned_pc_o(misaligned_pc_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid_i = 1'b0; redirect_pc_i = '0;
    trap_valid_i = 1'b0; trap_pc_i = '0;
    halt_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_ready_i = 1'b1; idle_inputs();
    tick(); tick();
    total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", pc_valid_o); end
    total++; if (pc_o !== RST) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_o, RST); end
    total++; if (misaligned_o !== 1'b0 || misaligned_pc_o !== 64'h0) begin
      bad++; $display("FAIL rst_mis got=%b/%h exp=0/0", misaligned_o, misaligned_pc_o); end
    reset = 1'b0; #1;
    total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b exp=0", pc_valid_o); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [3];
    exp_pc[0] = 64'h8000_0000; exp_pc[1] = 64'h8000_0004; exp_pc[2] = 64'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_valid_o !== 1'b1 || pc_o !== exp_pc[i]) begin
        bad++; $display("FAIL seq%0d got=%b/%h exp=1/%h", i, pc_valid_o, pc_o, exp_pc[i]); end
    end
    tick();
    total++; if (pc_o !== 64'h8000_000C) begin bad++; $display("FAIL seq3 got=%h exp=8000000c", pc_o); end
  endtask

  task automatic test_stall();
    tick();
    pc_ready_i = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (pc_valid_o !== 1'b1 || pc_o !== 64'h8000_0010) begin
        bad++; $display("FAIL stall%0d got=%b/%h exp=1/80000010", i, pc_valid_o, pc_o); end
      tick();
    end
    pc_ready_i = 1'b1; #1;
    total++; if (pc_o !== 64'h8000_0010) begin bad++; $display("FAIL stall_rel got=%h exp=80000010", pc_o); end
    tick();
    total++; if (pc_o !== 64'h8000_0014) begin bad++; $display("FAIL stall_next got=%h exp=80000014", pc_o); end
  endtask

  task automatic test_redirect();
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_1000;
    tick();
    total++; if (pc_valid_o !== 1'b1 || pc_o !== 64'h8000_1000) begin
      bad++; $display("FAIL redir got=%b/%h exp=1/80001000", pc_valid_o, pc_o); end
    redirect_pc_i = 64'h8000_3000; trap_valid_i = 1'b1; trap_pc_i = 64'h8000_2000;
    tick();
    idle_inputs();
    total++; if (pc_o !== 64'h8000_2000) begin bad++; $display("FAIL trap_prio got=%h exp=80002000", pc_o); end
    tick();
    total++; if (pc_o !== 64'h8000_2004) begin bad++; $display("FAIL post_trap got=%h exp=80002004", pc_o); end
  endtask

  task automatic test_halt();
    halt_i = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      redirect_valid_i = (i == 2); redirect_pc_i = 64'h8000_4000; #1;
      total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL halt%0d valid got=%b exp=0", i, pc_valid_o); end
      if (i == 1) begin
        total++; if (pc_o !== 64'h8000_2004) begin bad++; $display("FAIL halt_hold got=%h exp=80002004", pc_o); end
      end
      tick();
    end
    idle_inputs(); #1;
    total++; if (pc_valid_o !== 1'b1 || pc_o !== 64'h8000_4000) begin
      bad++; $display("FAIL halt_rel got=%b/%h exp=1/80004000", pc_valid_o, pc_o); end
  endtask

  task automatic test_wrap();
    redirect_valid_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    idle_inputs(); #1;
    total++; if (pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_pre got=%h exp=fffffffffffffffc", pc_o); end
    tick();
    total++; if (pc_valid_o !== 1'b1 || pc_o !== 64'h0) begin
      bad++; $display("FAIL wrap got=%b/%h exp=1/0", pc_valid_o, pc_o); end
  endtask

  task automatic test_misalign();
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_1002;
    tick();
    idle_inputs(); #1;
`ifdef PC_GEN_MISALIGN_CHECK_EN
    total++; if (misaligned_o !== 1'b1 || misaligned_pc_o !== 64'h8000_1002 || pc_valid_o !== 1'b0) begin
      bad++; $display("FAIL mis_fault got=%b/%h/%b exp=1/80001002/0", misaligned_o, misaligned_pc_o, pc_valid_o); end
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_5000;
    tick();
    total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL mis_redir_ignored got=%b exp=0", pc_valid_o); end
    redirect_valid_i = 1'b0; trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0100;
    tick();
    idle_inputs(); #1;
    total++; if (pc_valid_o !== 1'b1 || pc_o !== 64'h8000_0100) begin
      bad++; $display("FAIL mis_recover got=%b/%h exp=1/80000100", pc_valid_o, pc_o); end
    trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0201; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0300;
    tick();
    idle_inputs(); #1;
    total++; if (pc_valid_o !== 1'b0 || misaligned_pc_o !== 64'h8000_0201) begin
      bad++; $display("FAIL mis_trap_prio got=%b/%h exp=0/80000201", pc_valid_o, misaligned_pc_o); end
`else
    total++; if (pc_valid_o !== 1'b1 || pc_o !== 64'h8000_1000 || misaligned_o !== 1'b0) begin
      bad++; $display("FAIL mis_force got=%b/%h/%b exp=1/80001000/0", pc_valid_o, pc_o, misaligned_o); end
`endif
  endtask

  task automatic test_reset_mid();
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_7000;
    reset = 1'b1;
    tick();
    reset = 1'b0; idle_inputs(); #1;
    total++; if (pc_valid_o !== 1'b0 || pc_o !== RST || misaligned_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=%b/%h/%b exp=0/%h/0", pc_valid_o, pc_o, misaligned_o, RST); end
    tick();
    total++; if (pc_valid_o !== 1'b1 || pc_o !== RST) begin
      bad++; $display("FAIL rst_mid_run got=%b/%h exp=1/%h", pc_valid_o, pc_o, RST); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator that sits directly upstream of the fetch stage. It drives a 64-bit fetch address over a valid/ready handshake and advances sequentially by 4 on every accepted address. It accepts redirects from execute (branch/jump) and from the trap unit, and it can be stalled by a halt request. RV64 without the compressed extension, so all legal fetch addresses are 4-byte aligned.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset; must be 4-byte aligned.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- redirect_valid_i  in  1  branch/jump redirect request from execute.
- redirect_pc_i  in  64  redirect target.
- trap_valid_i  in  1  trap/exception redirect request.
- trap_pc_i  in  64  trap handler address.
- halt_i  in  1  level stall, e.g. WFI or pipeline hold; suppresses new fetch addresses.
- pc_o  out  64  fetch address to the fetch stage.
- pc_valid_o  out  1  pc_o is valid.
- pc_ready_i  in  1  fetch stage accepts pc_o.
- misaligned_o  out  1  misaligned redirect target detected (see Configuration).
- misaligned_pc_o  out  64  the offending target.

## Operation
- State register: BOOT, RUN, FAULT. A registered pc_q drives pc_o directly.
- Reset values:
  - state=BOOT, pc_q=RESET_PC.
  - pc_valid_o=0, misaligned_o=0, misaligned_pc_o=0.
- BOOT:
  - Always moves to RUN on the next cycle.
  - pc_valid_o=0.
  - A redirect or trap arriving in BOOT still loads pc_q.
- RUN:
  - pc_valid_o = ~halt_i (combinational).
  - Handshake = pc_valid_o & pc_ready_i.
- pc_q next-value priority, highest first:
  - trap_valid_i: pc_q <= trap_pc_i.
  - redirect_valid_i: pc_q <= redirect_pc_i.
  - handshake: pc_q <= pc_q + 4.
  - otherwise: hold.
- Arithmetic: the increment wraps modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC + 4 gives 0, with no flag.
- Redirect in the same cycle as a handshake: the current pc_o counts as issued, and the next pc_o is the redirect target, not pc+4.
- While valid is held and ready is low, pc_o stays stable. The only exception is a redirect or trap, which replaces the pending address on the next cycle. The fetch stage tolerates this.
- halt_i:
  - Only gates pc_valid_o.
  - Redirects and traps taken during halt update pc_q and are issued once halt_i drops.
- FAULT: see Configuration. pc_valid_o=0 in FAULT.

## Timing
- Reset deasserted at cycle 0: BOOT in cycle 0, first pc_valid_o=1 with pc_o=RESET_PC in cycle 1 (if halt_i=0).
- Redirect/trap sampled at cycle N: pc_o = target at N+1. One-cycle latency; no bubble beyond that cycle.
- Back-to-back handshakes: one address per cycle, sequential +4.
- Trap and redirect in the same cycle: the trap wins; the redirect is dropped.
- Reset mid-operation overrides everything: next cycle is BOOT, pc_q=RESET_PC, and outstanding redirect/fault state is cleared.
- halt_i asserted at cycle N: pc_valid_o=0 in cycle N, with no handshake in N.

## Configuration
- Macro: PC_GEN_MISALIGN_CHECK_EN.
- Defined:
  - A redirect or trap target with [1:0] != 0 sends the block to FAULT on the next cycle.
  - In FAULT: misaligned_o=1 (sticky), misaligned_pc_o=target, pc_valid_o=0, and pc_q is left unchanged.
  - FAULT exits only on trap_valid_i with an aligned trap_pc_i (to RUN, pc_q=trap_pc_i) or on reset.
  - A misaligned trap target entered from RUN or FAULT also gives FAULT.
  - Misaligned trap vs aligned redirect in the same cycle: the trap has priority, so FAULT.
- Undefined:
  - No FAULT state.
  - Target bits [1:0] are forced to 0 when loaded.
  - misaligned_o and misaligned_pc_o are tied to 0.

## Test plan
- Reset release, ready=1: pc_o sequence 8000_0000, 8000_0004, 8000_0008 on cycles 1..3; valid=0 in cycle 0.
- Ready low for 3 cycles at pc=8000_0010: pc_o holds 8000_0010 and valid stays 1; after ready rises, the next pc is 8000_0014.
- Redirect to 8000_1000 together with a handshake, then a trap to 8000_2000 plus a redirect to 8000_3000 in one cycle: pc_o=8000_1000, then 8000_2000.
- halt_i for 4 cycles with a redirect to 8000_4000 during the halt: valid=0 throughout; after release pc_o=8000_4000; then pc wrap from FFFF_FFFF_FFFF_FFFC gives 0.
- With the macro, redirect to 8000_1002: misaligned_o=1, misaligned_pc_o=8000_1002, valid=0. A trap to 8000_0100 recovers to RUN. Without the macro, the same redirect gives pc_o=8000_1000.
- Reset asserted in FAULT or mid-stream: next cycle BOOT, pc_o=RESET_PC, misaligned_o=0.
